// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit producing the hi/lo pair
// Shift-add multiply and restoring divide on operand magnitudes, sign applied in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;
  end

  // acc_hi holds the running upper product half or the partial remainder;
  // acc_lo holds the multiplier being shifted out or the dividend/quotient.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, mag_b};
    div_rem   = WIDTH'(div_shift - {1'b0, mag_b});
    if (is_div) begin
      step_hi = div_fits ? div_rem : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_fits};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    if (is_div) begin
      fix_hi = neg_r ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end else begin
      {fix_hi, fix_lo} = neg_q ? prod_neg : {acc_hi, acc_lo};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_pend  <= 1'b0;
      count    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            // Divide by zero still passes through FIX so its latency is one cycle.
            if (op[1] && (b == '0)) begin
              dz_pend <= 1'b1;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              mag_a   <= abs_a;
              mag_b   <= abs_b;
              acc_hi  <= '0;
              acc_lo  <= op[1] ? abs_a : abs_b;
              state   <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
          if (dz_pend) begin
            div_zero <= 1'b1;
          end else begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic        div_zero8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(2'b01), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          s;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] hold_hi = '0;
  logic [31:0] hold_lo = '0;
  logic        exp_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model32(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   r = 64'(sx * sy);
      2'b01:   r = {32'd0, x} * {32'd0, y};
      2'b10:   r = {32'(sx % sy), 32'(sx / sy)};
      default: r = {x % y, x / y};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
    end else begin
      exp_busy = 1'b0;
      if (q.size() > 0) exp_busy = (cyc >= q[0].s) && (cyc < q[0].s + q[0].lat);
      chk("busy", busy, exp_busy);
      if (q.size() > 0 && cyc == q[0].s + q[0].lat) begin
        chk("done", done, 1);
        chk("div_zero", div_zero, q[0].dz);
        if (!q[0].dz) begin
          hold_hi = q[0].hi;
          hold_lo = q[0].lo;
        end
        chk("hi", hi, hold_hi);
        chk("lo", lo, hold_lo);
        void'(q.pop_front());
      end else begin
        chk("no_done", done, 0);
        chk("hi_hold", hi, hold_hi);
        chk("lo_hold", lo, hold_lo);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] m;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.dz  = o[1] && (y == 32'd0);
    e.lat = e.dz ? 1 : 33;
    e.s   = cyc + 1;
    m     = e.dz ? 64'd0 : model32(o, x, y);
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    chk("drain_timeout", 64'(q.size()), 0);
    q.delete();
    @(posedge clk);
  endtask

  task automatic poke_busy(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[$];
  int   s8;
  int   t8;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;

    chk("pin_mult",   model32(2'b00, 32'h7, 32'hFFFFFFFD),        64'hFFFFFFFF_FFFFFFEB);
    chk("pin_multu",  model32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("pin_div",    model32(2'b10, 32'hFFFFFFF9, 32'h2),        64'hFFFFFFFF_FFFFFFFD);
    chk("pin_divu",   model32(2'b11, 32'h7, 32'h2),               64'h00000001_00000003);
    chk("pin_minneg", model32(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("pin_divneg", model32(2'b10, 32'h7, 32'hFFFFFFFE),        64'h00000001_FFFFFFFD);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    vecs.push_back('{2'b00, 32'h00000007, 32'hFFFFFFFD});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002});
    vecs.push_back('{2'b11, 32'h00000007, 32'h00000002});
    vecs.push_back('{2'b11, 32'h00000100, 32'h00000000});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000});
    vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE});
    vecs.push_back('{2'b10, 32'h00000000, 32'h00000005});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{2'b10, 32'h00000005, 32'h00000000});
    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF});

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      drain();
    end

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (32) @(posedge clk);
    issue(2'b10, 32'h7FFFFFFF, 32'hFFFFFFFD);
    drain();
    issue(2'b11, 32'h00000009, 32'h00000000);
    issue(2'b00, 32'hFFFFFF00, 32'h00000010);
    drain();

    // Reset part way through RUN, then a start during busy must be ignored.
    issue(2'b01, 32'hDEADBEEF, 32'h00000003);
    repeat (10) @(posedge clk);
    #1;
    reset   = 1'b0;
    q.delete();
    hold_hi = '0;
    hold_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    issue(2'b10, 32'hFFFFFF9C, 32'h00000007);
    repeat (5) @(posedge clk);
    poke_busy(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain();

    @(posedge clk);
    #1;
    start8 = 1'b1;
    a8     = 8'hFF;
    b8     = 8'hFF;
    s8     = cyc + 1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    t8     = -1;
    for (int i = 0; i < 30 && t8 < 0; i++) begin
      @(negedge clk);
      if (done8) t8 = cyc;
    end
    chk("w8_latency", 64'(t8 - s8), 64'd9);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);
    chk("w8_div_zero", div_zero8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
